// File: rtl/gzip_bitbuf_cxu.sv
// gzip_bitbuf_cxu: LSB-first deflate bit buffer custom-instruction unit.
// Optional total_bits statistics counter enabled by GZIP_BITBUF_STATS_EN.
module gzip_bitbuf_cxu #(
    parameter int BUF_W = 64,
    parameter int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        status_underflow,
    output logic        status_overflow
);

    localparam logic [CNT_W-1:0] PUSH_MAX = CNT_W'(BUF_W - 32);

    logic [BUF_W-1:0] r_buf;
    logic [BUF_W-1:0] w_buf_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_unf;
    logic             w_unf_nxt;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp;
    logic [31:0]      w_rsp_nxt;
    logic             w_fire;
    logic [5:0]       w_n;
    logic [CNT_W-1:0] w_n_c;
    logic [31:0]      w_mask;
    logic [31:0]      w_peek;
    logic             w_short;
    logic             w_push_ok;
    logic [2:0]       w_align;
    logic             w_unused;
`ifdef GZIP_BITBUF_STATS_EN
    logic [31:0]      r_total;
    logic [31:0]      w_total_nxt;
`endif

    assign cmd_ready = !r_rsp_valid || rsp_ready;
    assign w_fire    = cmd_valid && cmd_ready;
    assign w_unused  = ^cmd_payload_inputs_1[31:6];

    assign w_n = (cmd_payload_inputs_1[5:0] > 6'd32) ? 6'd32 : cmd_payload_inputs_1[5:0];
    assign w_n_c = CNT_W'(w_n);
    // 1<<32 wraps to 0 in 32 bits, so n=32 yields an all-ones mask.
    assign w_mask    = (32'd1 << w_n) - 32'd1;
    // Bits above cnt are zero, so this is also the cnt-bit value on underflow.
    assign w_peek    = r_buf[31:0] & w_mask;
    assign w_short   = w_n_c > r_cnt;
    assign w_push_ok = r_cnt <= PUSH_MAX;
    assign w_align   = r_cnt[2:0];

    // Next buffer state and response for the command being presented.
    always_comb begin
        w_buf_nxt = r_buf;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        w_rsp_nxt = 32'd0;
`ifdef GZIP_BITBUF_STATS_EN
        w_total_nxt = r_total;
`endif
        unique case (cmd_payload_function_id)
            3'b000: begin
                if (w_push_ok) begin
                    w_buf_nxt = r_buf | (BUF_W'(cmd_payload_inputs_0) << r_cnt);
                    w_cnt_nxt = r_cnt + CNT_W'(32);
                end else begin
                    w_ovf_nxt = 1'b1;
                end
                w_rsp_nxt = 32'(w_cnt_nxt);
            end
            3'b001: begin
                w_rsp_nxt = w_peek;
                if (w_short) w_unf_nxt = 1'b1;
            end
            3'b010, 3'b011: begin
                if (w_short) begin
                    w_unf_nxt = 1'b1;
                end else begin
                    w_buf_nxt = r_buf >> w_n;
                    w_cnt_nxt = r_cnt - w_n_c;
`ifdef GZIP_BITBUF_STATS_EN
                    w_total_nxt = r_total + 32'(w_n);
`endif
                end
                w_rsp_nxt = cmd_payload_function_id[0] ? 32'(w_cnt_nxt) : w_peek;
            end
            3'b100: w_rsp_nxt = 32'(r_cnt);
            3'b101: begin
                w_buf_nxt = r_buf >> w_align;
                w_cnt_nxt = r_cnt - CNT_W'(w_align);
`ifdef GZIP_BITBUF_STATS_EN
                w_total_nxt = r_total + 32'(w_align);
`endif
                w_rsp_nxt = 32'(w_cnt_nxt);
            end
            3'b110: begin
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
`ifdef GZIP_BITBUF_STATS_EN
                w_total_nxt = 32'd0;
`endif
            end
            3'b111: begin
`ifdef GZIP_BITBUF_STATS_EN
                w_rsp_nxt = r_total;
`else
                w_rsp_nxt = 32'd0;
`endif
            end
            default: w_rsp_nxt = 32'd0;
        endcase
    end

    // Commit state and load the response register on accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= 32'd0;
`ifdef GZIP_BITBUF_STATS_EN
            r_total     <= 32'd0;
`endif
        end else if (w_fire) begin
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_unf       <= w_unf_nxt;
            r_rsp_valid <= 1'b1;
            r_rsp       <= w_rsp_nxt;
`ifdef GZIP_BITBUF_STATS_EN
            r_total     <= w_total_nxt;
`endif
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid             = r_rsp_valid;
    assign rsp_payload_outputs_0 = r_rsp;
    assign status_underflow      = r_unf;
    assign status_overflow       = r_ovf;

endmodule
